// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared types and constants for the instruction memory loader.
//   state_e       : loader FSM state encoding (ST_RX_SUM only with IMEM_LOADER_CHKSUM_EN)
//   DEF_MEM_BYTES : default instruction memory size in bytes
//   DEF_BASE_ADDR : default byte address of the first written word
//   MAX_WORDS     : word capacity for the default memory size
//   max_words()   : word capacity for an arbitrary memory size
// Optional feature macro: IMEM_LOADER_CHKSUM_EN
package imem_loader_pkg;

  localparam int unsigned DEF_MEM_BYTES = 8192;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
  localparam int unsigned MAX_WORDS     = DEF_MEM_BYTES / 4;

  function automatic int unsigned max_words(input int unsigned mem_bytes);
    return mem_bytes / 4;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_LEN,
    ST_RX_DATA,
`ifdef IMEM_LOADER_CHKSUM_EN
    ST_RX_SUM,
`endif
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if -- control, byte stream and memory write bus of the loader.
//   start_i        : pulse that begins a load
//   byte_valid_i   : stream byte valid
//   byte_data_i    : stream byte
//   byte_ready_o   : loader accepts a byte this cycle
//   wr_en_o        : one-cycle memory write strobe
//   wr_addr_o      : word-aligned byte address of the write
//   wr_data_o      : little-endian write word
//   busy_o/done_o/err_o : load status
// modport slave is the loader side, modport master the driver side.
interface imem_loader_if;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  modport slave (
    input  start_i, byte_valid_i, byte_data_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/imem_word_assembler.sv
// imem_word_assembler -- packs accepted stream bytes into little-endian words.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   i_clr      : drop any partial word (new load)
//   i_en       : a byte is accepted this cycle
//   i_byte     : accepted byte
//   o_word     : assembled word, valid while o_word_rdy is high
//   o_word_rdy : pulses in the cycle the 4th byte of a word is accepted
module imem_word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_rdy
);
  logic [1:0]  r_idx;
  logic [23:0] r_shift;

  // Bytes enter at the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_clr) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_en) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  assign o_word_rdy = i_en && (r_idx == 2'd3);
  assign o_word     = {i_byte, r_shift};
endmodule

// File: rtl/imem_loader.sv
// imem_loader -- loads a length-prefixed byte stream into instruction memory.
//   MEM_BYTES : memory size in bytes (MAX_WORDS = MEM_BYTES/4)
//   BASE_ADDR : byte address of the first written word
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   bus       : imem_loader_if.slave (start, byte stream, write bus, status)
// Stream: 4-byte little-endian word count N, then N*4 payload bytes.
// Macro IMEM_LOADER_CHKSUM_EN adds a trailing XOR-of-payload checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  imem_loader_if.slave  bus
);
  localparam logic [31:0] LP_MAX_WORDS = 32'(max_words(MEM_BYTES));

  state_e      r_state;
  logic        r_rdy, r_busy, r_done, r_err, r_wr_en;
  logic [31:0] r_wr_addr, r_wr_data, r_len, r_cnt;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]  r_xor;
`endif

  logic        w_acc, w_start, w_word_rdy;
  logic [31:0] w_word;

  assign w_acc   = bus.byte_valid_i & r_rdy;
  assign w_start = bus.start_i & (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});

  // The same packer assembles both the length word and the payload words.
  imem_word_assembler u_asm (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_clr      (w_start),
    .i_en       (w_acc),
    .i_byte     (bus.byte_data_i),
    .o_word     (w_word),
    .o_word_rdy (w_word_rdy)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
      r_xor     <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (w_start) begin
            r_state <= ST_RX_LEN;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            r_xor   <= '0;
`endif
          end
        end
        ST_RX_LEN: begin
          if (w_word_rdy) begin
            r_len <= w_word;
            if (w_word == '0) begin
              r_state <= ST_DONE;
              r_rdy   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_word > LP_MAX_WORDS) begin
              r_state <= ST_ERROR;
              r_rdy   <= 1'b0;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_RX_DATA;
            end
          end
        end
        ST_RX_DATA: begin
`ifdef IMEM_LOADER_CHKSUM_EN
          if (w_acc) r_xor <= r_xor ^ bus.byte_data_i;
`endif
          if (w_word_rdy) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= BASE_ADDR + {r_cnt[29:0], 2'b00};
            r_wr_data <= w_word;
            r_cnt     <= r_cnt + 32'd1;
            if (r_cnt == r_len - 32'd1) begin
`ifdef IMEM_LOADER_CHKSUM_EN
              r_state <= ST_RX_SUM;
`else
              r_state <= ST_DONE;
              r_rdy   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHKSUM_EN
        ST_RX_SUM: begin
          if (w_acc) begin
            r_rdy  <= 1'b0;
            r_busy <= 1'b0;
            if (bus.byte_data_i == r_xor) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready_o = r_rdy;
  assign bus.wr_en_o      = r_wr_en;
  assign bus.wr_addr_o    = r_wr_addr;
  assign bus.wr_data_o    = r_wr_data;
  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.err_o        = r_err;
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_BYTES, default 8192, SHALL be the instruction memory size in bytes; MAX_WORDS = MEM_BYTES/4.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL be the byte address of the first written word.
REQ-003 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 start_i  in  1  pulse that begins a load.
REQ-006 byte_valid_i  in  1  byte_data_i holds a valid stream byte.
REQ-007 byte_data_i  in  8  stream byte.
REQ-008 byte_ready_o  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid_i and byte_ready_o are both 1.
REQ-009 wr_en_o  out  1  one-cycle instruction memory write strobe.
REQ-010 wr_addr_o  out  32  byte address of the write, word aligned.
REQ-011 wr_data_o  out  32  little-endian word: the first received byte SHALL be bits [7:0].
REQ-012 busy_o  out  1  load in progress.
REQ-013 done_o  out  1  load completed successfully; held until the next start_i or reset.
REQ-014 err_o  out  1  load aborted; held until the next start_i or reset.

Function
REQ-015 FSM states SHALL be IDLE, RX_LEN, RX_DATA, RX_SUM and DONE, ERROR; RX_SUM SHALL exist only when the checksum macro is defined.
REQ-016 Stream format: a 4-byte little-endian word count N, then N*4 payload bytes.
REQ-017 byte_ready_o SHALL be 1 only in RX_LEN, RX_DATA and RX_SUM; there is no other backpressure.
REQ-018 start_i in IDLE, DONE or ERROR SHALL move the FSM to RX_LEN, clear done_o, err_o and the word counter, and discard any partial byte; start_i in the RX states SHALL be ignored.
REQ-019 When the 4th length byte is accepted: if N=0, the FSM SHALL go to DONE with no write; if N>MAX_WORDS, to ERROR; otherwise to RX_DATA.
REQ-020 In RX_DATA, bytes SHALL be packed by a 2-bit byte index. On the 4th byte, wr_en_o SHALL pulse in the following cycle (registered, latency 1) with wr_addr_o = BASE_ADDR + 4*k for word k, k = 0..N-1.
REQ-021 After word N-1 is accepted, the FSM SHALL go to DONE, or to RX_SUM when the checksum is enabled.
REQ-022 wr_addr_o SHALL wrap modulo 32 bits; the N<=MAX_WORDS check keeps writes inside memory.
REQ-023 busy_o SHALL equal 1 in RX_LEN, RX_DATA and RX_SUM.
REQ-024 A byte presented while ready is low SHALL be ignored and SHALL NOT be counted.

Reset
REQ-025 rst_ni low SHALL immediately force: IDLE state; byte_ready_o, wr_en_o, busy_o, done_o and err_o to 0; wr_addr_o and wr_data_o to 0; all counters to 0.
REQ-026 Reset during a load SHALL abandon it without completing the pending write; memory contents already written are unaffected.

Configuration
REQ-027 Macro IMEM_LOADER_CHKSUM_EN defined: one extra byte SHALL follow the payload, equal to the XOR of all payload bytes. A match SHALL go to DONE; a mismatch SHALL go to ERROR. Words already written SHALL remain written.
REQ-028 Macro not defined: no checksum byte, no RX_SUM state, and no XOR logic is synthesized.

Structure
REQ-029 Package imem_loader_pkg SHALL hold the state enum typedef and the MAX_WORDS/default constants.
REQ-030 Sub-module imem_word_assembler SHALL contain the byte-to-word packer: byte index, shift register and word-ready pulse.

Verification
REQ-031 start_i, then bytes 01 00 00 00 13 05 A0 00 -> one wr_en_o pulse with wr_addr_o=0x0, wr_data_o=0x00A00513, then done_o=1.
REQ-032 N=3 with 12 bytes and byte_valid_i toggling every other cycle -> writes at 0x0, 0x4, 0x8 in order, exactly 3 pulses.
REQ-033 Length bytes 01 08 00 00 (N=2049), default MEM_BYTES -> err_o=1, no wr_en_o.
REQ-034 Length 00 00 00 00 -> done_o=1 one cycle after the 4th byte, no write.
REQ-035 rst_ni asserted after 6 payload bytes of an N=2 load -> outputs zero immediately, only 1 write observed; a new start_i with a correct stream succeeds.
REQ-036 With IMEM_LOADER_CHKSUM_EN defined, payload 13 05 A0 00 followed by B6 -> done_o=1; followed by 00 -> err_o=1, with 1 write performed.
